// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master is the loader side; slave is the stream source / memory side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_addr,
        output mem_wd,
        output mem_we
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_addr,
        input  mem_wd,
        input  mem_we
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them into instruction memory and holds the CPU in reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte; validate length
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle write of the assembled word to memory
// DONE  | image complete, CPU released, wait for reload request
// ERR   | length header rejected, CPU held, wait for reload request
module imem_loader #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    state_t      state, state_nx;
    logic [15:0] len_q, len_nx;
    logic [15:0] idx_q, idx_nx;
    logic [1:0]  bc_q, bc_nx;
    logic [31:0] word_q, word_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wd_q, wd_nx;

    logic        xfer;
    logic [15:0] len_full;
    logic        len_bad;

    assign xfer     = bus.in_valid && bus.in_ready;
    assign len_full = {bus.in_data, len_q[7:0]};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LEN0;
            len_q  <= '0;
            idx_q  <= '0;
            bc_q   <= '0;
            word_q <= '0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            state  <= state_nx;
            len_q  <= len_nx;
            idx_q  <= idx_nx;
            bc_q   <= bc_nx;
            word_q <= word_nx;
            addr_q <= addr_nx;
            wd_q   <= wd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        idx_nx   = idx_q;
        bc_nx    = bc_q;
        word_nx  = word_q;
        addr_nx  = addr_q;
        wd_nx    = wd_q;

        case (state)
            S_LEN0: begin
                if (xfer) begin
                    len_nx   = {8'h00, bus.in_data};
                    state_nx = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_nx   = len_full;
                    idx_nx   = '0;
                    bc_nx    = '0;
                    state_nx = len_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    case (bc_q)
                        2'd0:    word_nx[7:0]   = bus.in_data;
                        2'd1:    word_nx[15:8]  = bus.in_data;
                        2'd2:    word_nx[23:16] = bus.in_data;
                        default: word_nx[31:24] = bus.in_data;
                    endcase
                    bc_nx = bc_q + 2'd1;
                    // Output registers load with the final lane so the word is
                    // presented in full during the WRITE cycle.
                    if (bc_q == 2'd3) begin
                        addr_nx  = {14'd0, idx_q, 2'b00};
                        wd_nx    = {bus.in_data, word_q[23:0]};
                        state_nx = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_nx   = idx_q + 16'd1;
                state_nx = (idx_q + 16'd1 == len_q) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                if (start) state_nx = S_LEN0;
            end
            S_ERR: begin
                if (start) state_nx = S_LEN0;
            end
            default: state_nx = S_LEN0;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = addr_q;
        bus.mem_wd   = wd_q;
        cpu_rst      = 1'b1;
        done         = 1'b0;
        err          = 1'b0;

        case (state)
            S_LEN0, S_LEN1, S_DATA: bus.in_ready = 1'b1;
            S_WRITE:                bus.mem_we   = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:                  err          = 1'b1;
            default: ;
        endcase
    end

    // The memory port is shared with the CPU fetch path, selected by cpu_rst.
    a_no_write_while_running: assert property (
        @(posedge clk) disable iff (rst) bus.mem_we |-> cpu_rst);
    a_done_err_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(done && err));

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random images with random stream gaps,
// length rejection, mid-word reset and reload behaviour.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst;
    logic done;
    logic err;

    imem_loader_if bus ();

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          n_writes = 0;
    int          done_cyc = 0;
    logic [31:0] last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: every write cycle must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.mem_we) begin
            n_writes++;
            last_addr = bus.mem_addr;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %08h data %08h, no write expected",
                         bus.mem_addr, bus.mem_wd);
            end else begin
                e = exp_q.pop_front();
                check32("wr_addr", bus.mem_addr, e.addr);
                check32("wr_data", bus.mem_wd, e.data);
                check1("wr_in_ready", bus.in_ready, 1'b0);
                check1("wr_cpu_rst", cpu_rst, 1'b1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        int budget;
        gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        while (!bus.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check1("byte_accept", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!done && !err && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        done_cyc = cyc;
        check1("done_reached", done, 1'b1);
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Reference: a header is legal iff 1 <= N <= DEPTH; a legal image yields
    // N writes, word i at byte address 4*i; a start at data byte start_at is ignored.
    task automatic run_image(input int n, input int gapmax, input int start_at);
        bit          ok;
        logic [31:0] w;
        wr_t         e;
        ok = (n >= 1) && (n <= DEPTH);
        send_byte(8'(n), gapmax);
        send_byte(8'(n >> 8), gapmax);
        if (!ok) begin
            check1("hdr_err", err, 1'b1);
            check1("hdr_err_cpu_rst", cpu_rst, 1'b1);
            check1("hdr_err_in_ready", bus.in_ready, 1'b0);
            check1("hdr_err_no_we", bus.mem_we, 1'b0);
            return;
        end
        check1("hdr_ok_no_err", err, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            e.addr = 32'(4 * i);
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k == start_at) begin
                    pulse_start();
                    check1("start_ignored_ready", bus.in_ready, 1'b1);
                    check1("start_ignored_cpu_rst", cpu_rst, 1'b1);
                    check1("start_ignored_done", done, 1'b0);
                end
                send_byte(w[8*k +: 8], gapmax);
            end
        end
        wait_done();
        check1("done_cpu_rst", cpu_rst, 1'b0);
        check1("done_in_ready", bus.in_ready, 1'b0);
        check1("done_no_err", err, 1'b0);
        check32("done_all_written", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          c0;
        int          w0;
        logic [31:0] w;
        wr_t         e;

        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);

        check1("rst_in_ready", bus.in_ready, 1'b1);
        check1("rst_mem_we", bus.mem_we, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_cpu_rst", cpu_rst, 1'b1);
        check32("rst_mem_addr", bus.mem_addr, 32'd0);
        check32("rst_mem_wd", bus.mem_wd, 32'd0);

        // N=1 continuous: 01 00 13 05 a0 00, DONE 7 cycles after release.
        rst = 1'b0;
        c0  = cyc;
        img.delete();
        img.push_back(32'h00a00513);
        run_image(1, 0, -1);
        check32("n1_latency", 32'(done_cyc - c0), 32'd7);

        // Reload from DONE.
        pulse_start();
        check1("reload_cpu_rst", cpu_rst, 1'b1);
        check1("reload_done", done, 1'b0);
        check1("reload_in_ready", bus.in_ready, 1'b1);

        // N=3 with gaps, overwrites address 0 onward.
        fill_img(3);
        run_image(3, 4, -1);

        for (int it = 0; it < 3; it++) begin
            int n;
            n = int'($urandom_range(8, 1));
            pulse_start();
            fill_img(n);
            run_image(n, 3, -1);
        end

        // start during DATA is ignored.
        pulse_start();
        fill_img(2);
        run_image(2, 1, 2);

        // N=0 rejected, then recovery.
        pulse_start();
        run_image(0, 0, -1);
        pulse_start();
        check1("err_cleared", err, 1'b0);
        check1("err_cleared_ready", bus.in_ready, 1'b1);
        fill_img(1);
        run_image(1, 2, -1);

        // N=DEPTH+1 rejected; N=DEPTH accepted, last write at 0xFC.
        pulse_start();
        run_image(DEPTH + 1, 1, -1);
        pulse_start();
        fill_img(DEPTH);
        w0 = n_writes;
        run_image(DEPTH, 1, -1);
        check32("full_write_count", 32'(n_writes - w0), 32'(DEPTH));
        check32("full_last_addr", last_addr, 32'h0000_00fc);

        // Reset after 2 bytes of word 1: word 0 written, word 1 dropped.
        pulse_start();
        w0 = n_writes;
        send_byte(8'd2, 1);
        send_byte(8'd0, 1);
        w = $urandom;
        e.addr = 32'd0;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1);
        w = $urandom;
        send_byte(w[7:0], 1);
        send_byte(w[15:8], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("midrst_cpu_rst", cpu_rst, 1'b1);
        check1("midrst_in_ready", bus.in_ready, 1'b1);
        check1("midrst_done", done, 1'b0);
        check32("midrst_mem_addr", bus.mem_addr, 32'd0);
        check32("midrst_mem_wd", bus.mem_wd, 32'd0);
        repeat (3) @(negedge clk);
        check32("midrst_writes", 32'(n_writes - w0), 32'd1);
        check32("midrst_queue", 32'(exp_q.size()), 32'd0);
        check1("midrst_cpu_rst_hold", cpu_rst, 1'b1);
        fill_img(2);
        run_image(2, 2, -1);

        repeat (2) @(negedge clk);
        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
